// File: rtl/mc_control_pkg.sv
// mc_control_pkg: state encodings, opcodes, datapath select codes and the control word for mc_control.
package mc_control_pkg;
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE   = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    JUMP      = 4'd10,
    ADDI_EX   = 4'd11,
    ADDI_WB   = 4'd12,
    ILLEGAL   = 4'd13
  } state_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;
endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: control unit <-> datapath signals; master is the control unit.
interface mc_control_if #(parameter int OP_W = 6);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;
  logic            PCWrite;
  logic            IorD;
  logic            MemRead;
  logic            MemWrite;
  logic            IRWrite;
  logic            MemtoReg;
  logic            RegDst;
  logic            RegWrite;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ALUOp;
  logic [1:0]      PCSource;
  logic            illegal_op;
  logic [3:0]      state_out;
  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state_out
  );
  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
           ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state_out
  );
endinterface

// File: rtl/mc_control_decode.sv
// mc_control_decode: combinational control word from state, zero flag and memory handshake.
module mc_control_decode
  import mc_control_pkg::*;
(
  input  state_t state,
  input  logic   zero,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: ctrl.alu_src_b = SRCB_SHIFT;
      MEM_ADDR, ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PC_ALUOUT;
        ctrl.pc_write  = zero;
      end
      JUMP: begin
        ctrl.pc_source = PC_JUMP;
        ctrl.pc_write  = 1'b1;
      end
      ADDI_WB: ctrl.reg_write = 1'b1;
      ILLEGAL: ctrl.illegal_op = 1'b1;
      default: ctrl = '0;
    endcase
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle main control FSM; state register and next-state logic, outputs decoded from state.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);
  state_t state, nxt;
  ctrl_t  ctrl;
  logic   is_lw, is_sw;
  assign is_lw = bus.opcode == OP_W'(OP_LW);
  assign is_sw = bus.opcode == OP_W'(OP_SW);
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:      nxt = FETCH;
      FETCH:     nxt = bus.mem_ready ? DECODE : FETCH;
      DECODE:    nxt = (is_lw || is_sw)                ? MEM_ADDR :
                       bus.opcode == OP_W'(OP_R)       ? EXECUTE  :
                       bus.opcode == OP_W'(OP_BEQ)     ? BRANCH   :
                       bus.opcode == OP_W'(OP_J)       ? JUMP     :
                       bus.opcode == OP_W'(OP_ADDI)    ? ADDI_EX  : ILLEGAL;
      MEM_ADDR:  nxt = is_lw ? MEM_READ : MEM_WRITE;
      MEM_READ:  nxt = bus.mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: nxt = bus.mem_ready ? FETCH : MEM_WRITE;
      EXECUTE:   nxt = R_WB;
      ADDI_EX:   nxt = ADDI_WB;
      MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, ILLEGAL: nxt = FETCH;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  mc_control_decode u_decode (
    .state     (state),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.IorD       = ctrl.iord;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.PCSource   = ctrl.pc_source;
  assign bus.illegal_op = ctrl.illegal_op;
  assign bus.state_out  = state;
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: per-cycle scoreboard of expected state and control word for each instruction class.
module tb_mc_control;
  import mc_control_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mc_control_if #(.OP_W(6)) bus ();
  mc_control #(.OP_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0]  st;
    logic [15:0] out;
  } exp_t;
  exp_t sb[$];
  function automatic logic [15:0] obs();
    return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg,
            bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource,
            bus.illegal_op};
  endfunction
  // flags: pcw iord mrd mwr irw m2r rd rw srca, then srcb, aluop, pcsrc, illegal
  function automatic logic [15:0] exp_out(input int s, input logic z, input logic m);
    logic [8:0] f;
    logic [1:0] b, a, p;
    logic       il;
    f = '0; b = '0; a = '0; p = '0; il = 1'b0;
    case (s)
      1:  begin f = {m, 1'b0, 1'b1, 1'b0, m, 4'b0000}; b = 2'b01; end
      2:  b = 2'b11;
      3:  begin f = 9'b000000001; b = 2'b10; end
      4:  f = 9'b011000000;
      5:  f = 9'b000001010;
      6:  f = 9'b010100000;
      7:  begin f = 9'b000000001; a = 2'b10; end
      8:  f = 9'b000000110;
      9:  begin f = {z, 8'b00000001}; a = 2'b01; p = 2'b01; end
      10: begin f = 9'b100000000; p = 2'b10; end
      11: begin f = 9'b000000001; b = 2'b10; end
      12: f = 9'b000000010;
      13: il = 1'b1;
      default: ;
    endcase
    return {f, b, a, p, il};
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic m, input logic z, input int s);
    exp_t e;
    @(negedge clk);
    bus.mem_ready = m;
    bus.zero = z;
    sb.push_back('{4'(s), exp_out(s, z, m)});
    #1;
    e = sb.pop_front();
    chk($sformatf("state(op=%h)", bus.opcode), 16'(bus.state_out), 16'(e.st));
    chk($sformatf("ctrl(st=%0d)", e.st), obs(), e.out);
  endtask
  task automatic instr(input logic [5:0] op, input logic z, input int fs, input int ms);
    bus.opcode = op;
    repeat (fs) step(1'b0, z, 1);
    step(1'b1, z, 1);
    step(1'b1, z, 2);
    case (op)
      OP_LW: begin
        step(1'b1, z, 3);
        repeat (ms) step(1'b0, z, 4);
        step(1'b1, z, 4);
        step(1'b1, z, 5);
      end
      OP_SW: begin
        step(1'b1, z, 3);
        repeat (ms) step(1'b0, z, 6);
        step(1'b1, z, 6);
      end
      OP_R:    begin step(1'b1, z, 7); step(1'b1, z, 8); end
      OP_BEQ:  step(1'b1, z, 9);
      OP_J:    step(1'b1, z, 10);
      OP_ADDI: begin step(1'b1, z, 11); step(1'b1, z, 12); end
      default: step(1'b1, z, 13);
    endcase
  endtask
  initial begin
    bus.opcode = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    reset = 1'b0;
    instr(OP_LW, 1'b0, 0, 0);
    instr(OP_BEQ, 1'b1, 0, 0);
    instr(OP_BEQ, 1'b0, 0, 0);
    instr(OP_SW, 1'b0, 0, 3);
    instr(6'h3f, 1'b0, 0, 0);
    instr(OP_R, 1'b0, 0, 0);
    instr(OP_J, 1'b1, 0, 0);
    instr(OP_ADDI, 1'b0, 0, 0);
    instr(OP_LW, 1'b1, 2, 1);
    bus.opcode = OP_LW;
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 2);
    step(1'b1, 1'b0, 3);
    step(1'b0, 1'b0, 4);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_state", 16'(bus.state_out), 16'h0);
    chk("async_rst_ctrl", obs(), 16'h0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    reset = 1'b0;
    instr(OP_ADDI, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
